// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings and default timing constants for the CPU run/step/breakpoint controller.
package cpu_run_ctrl_pkg;

  localparam int unsigned PC_W           = 32;
  localparam int unsigned CNT_W          = 32;
  localparam int unsigned DIV_FAST_DEF   = 4;
  localparam int unsigned DIV_SLOW_DEF   = 50_000_000;
  localparam int unsigned DEB_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, accepted level and rise pulse.
module btn_debounce
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Level flips only after DEB_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      s1         <= btn;
      s2         <= s1;
      rise_pulse <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level      <= s2;
        rise_pulse <= s2;
        cnt        <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU clock-enable generator: fast/slow free-run, debounced single-step and PC breakpoint.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned DIV_FAST   = DIV_FAST_DEF,
  parameter int unsigned DIV_SLOW   = DIV_SLOW_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            sw_speed,
  input  logic            sw_run,
  input  logic            btn_step,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_pc,
  input  logic [PC_W-1:0] pc,
  output logic            cpu_ce,
  output logic            halted,
  output logic [1:0]      state_o,
  output logic [31:0]     ce_count
);

  run_state_e       state;
  run_state_e       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] div_m1;
  logic             bp_skip;
  logic             skip_d;
  logic             ce_d;
  logic             issue_pt;
  logic             bp_hit;

  logic       run_s1;
  logic       run_s2;
  logic       run_d;
  logic [1:0] run_fill;
  logic       run_rise;
  logic       btn_level;
  logic       btn_rise;
  logic       step_pulse;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_deb (
    .clk       (clk),
    .rstn      (rstn),
    .btn       (btn_step),
    .level     (btn_level),
    .rise_pulse(btn_rise)
  );

  assign step_pulse = btn_rise & btn_level;

  // run_fill masks edges until the synchronizer and edge flop hold real samples,
  // so a switch already high at reset release is not mistaken for a rise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_s1   <= 1'b0;
      run_s2   <= 1'b0;
      run_d    <= 1'b0;
      run_fill <= 2'd0;
    end else begin
      run_s1 <= sw_run;
      run_s2 <= run_s1;
      run_d  <= run_s2;
      if (run_fill != 2'd3) run_fill <= run_fill + 2'd1;
    end
  end

  assign run_rise = (run_fill == 2'd3) && run_s2 && !run_d;

  assign div_m1   = sw_speed ? CNT_W'(DIV_SLOW - 1) : CNT_W'(DIV_FAST - 1);
  assign issue_pt = (cnt >= div_m1);
  assign bp_hit   = bp_en && !bp_skip && (pc == bp_pc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_HALT;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_HALT: begin
        if (step_pulse)    state_d = ST_STEP;
        else if (run_rise) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run_s2)                state_d = ST_HALT;
        else if (issue_pt && bp_hit) state_d = ST_BREAK;
      end
      ST_STEP: state_d = ST_HALT;
      ST_BREAK: begin
        if (step_pulse)   state_d = ST_STEP;
        else if (!run_s2) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Next values of the registered outputs and the divider.
  always_comb begin
    ce_d   = 1'b0;
    cnt_d  = '0;
    skip_d = bp_skip;
    if (state_d == ST_STEP) begin
      ce_d = 1'b1;
    end else if (state_d == ST_RUN) begin
      if (state != ST_RUN) begin
        skip_d = 1'b1;
      end else if (issue_pt) begin
        ce_d   = 1'b1;
        skip_d = 1'b0;
      end else begin
        cnt_d = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      bp_skip  <= 1'b1;
      cpu_ce   <= 1'b0;
      ce_count <= '0;
      halted   <= 1'b1;
    end else begin
      cnt     <= cnt_d;
      bp_skip <= skip_d;
      cpu_ce  <= ce_d;
      halted  <= (state_d == ST_HALT) || (state_d == ST_BREAK);
      if (ce_d) ce_count <= ce_count + 32'd1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: table of run phases plus step, breakpoint and reset sequences.
module tb_cpu_run_ctrl;

  localparam int unsigned DIV_FAST   = 4;
  localparam int unsigned DIV_SLOW   = 16;
  localparam int unsigned DEB_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sw_speed;
  logic        sw_run;
  logic        btn_step;
  logic        bp_en;
  logic [31:0] bp_pc;
  logic [31:0] pc = 32'd0;
  logic        cpu_ce;
  logic        halted;
  logic [1:0]  state_o;
  logic [31:0] ce_count;

  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        run;
    logic        speed;
    int          cycles;
    int          exp_pulses;
    int          exp_gap;
    logic [1:0]  exp_state;
    logic        exp_halted;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[5];

  cpu_run_ctrl #(
    .DIV_FAST  (DIV_FAST),
    .DIV_SLOW  (DIV_SLOW),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sw_speed(sw_speed),
    .sw_run  (sw_run),
    .btn_step(btn_step),
    .bp_en   (bp_en),
    .bp_pc   (bp_pc),
    .pc      (pc),
    .cpu_ce  (cpu_ce),
    .halted  (halted),
    .state_o (state_o),
    .ce_count(ce_count)
  );

  always #5 clk = ~clk;

  // CPU stand-in: PC advances by 4 per cpu_ce and wraps within 0x00..0x1C.
  always @(negedge clk) begin
    if (pc_load)     pc = pc_load_val;
    else if (cpu_ce) pc = (pc + 32'd4) & 32'h1F;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ce(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (cpu_ce) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_until_break(input int limit, output bit done, output int n,
                                 output logic [31:0] first_pc);
    done     = 1'b0;
    n        = 0;
    first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (cpu_ce) begin
        if (n == 0) first_pc = pc;
        n++;
      end
      if (state_o == 2'b11) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load_val = v;
    pc_load     = 1'b1;
    tick();
    pc_load     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int          pulses;
    int          last;
    bit          seen;
    bit          done;
    int          n;
    logic [31:0] first_pc;
    logic [31:0] exp_cnt;

    //         run   speed cyc pulses gap state  halted count
    vecs[0] = '{1'b1, 1'b0, 100, 0,  0,  2'b00, 1'b1, 32'd0};
    vecs[1] = '{1'b0, 1'b0, 6,   0,  0,  2'b00, 1'b1, 32'd0};
    vecs[2] = '{1'b1, 1'b0, 45,  10, 4,  2'b01, 1'b0, 32'd10};
    vecs[3] = '{1'b1, 1'b1, 56,  3,  16, 2'b01, 1'b0, 32'd13};
    vecs[4] = '{1'b0, 1'b1, 20,  0,  0,  2'b00, 1'b1, 32'd13};

    rstn     = 1'b0;
    sw_run   = 1'b1;
    sw_speed = 1'b0;
    btn_step = 1'b0;
    bp_en    = 1'b0;
    bp_pc    = 32'd0;
    idle(3);
    check("reset state_o", 32'(state_o), 32'd0);
    check("reset halted", 32'(halted), 32'd1);
    check("reset cpu_ce", 32'(cpu_ce), 32'd0);
    check("reset ce_count", ce_count, 32'd0);
    rstn = 1'b1;

    for (int v = 0; v < 5; v++) begin
      sw_run   = vecs[v].run;
      sw_speed = vecs[v].speed;
      pulses   = 0;
      last     = -1;
      for (int c = 1; c <= vecs[v].cycles; c++) begin
        tick();
        if (cpu_ce) begin
          if (last >= 0 && vecs[v].exp_gap != 0)
            check($sformatf("vec%0d pulse gap", v), 32'(c - last), 32'(vecs[v].exp_gap));
          last = c;
          pulses++;
        end
      end
      check($sformatf("vec%0d pulses", v), 32'(pulses), 32'(vecs[v].exp_pulses));
      check($sformatf("vec%0d state_o", v), 32'(state_o), 32'(vecs[v].exp_state));
      check($sformatf("vec%0d halted", v), 32'(halted), 32'(vecs[v].exp_halted));
      check($sformatf("vec%0d ce_count", v), ce_count, vecs[v].exp_count);
    end
    exp_cnt = 32'd13;

    // Bouncy button then a clean press: exactly one step.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      btn_step = (i % 2 == 0);
      tick();
      if (cpu_ce) pulses++;
    end
    btn_step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_ce) begin
        pulses++;
        check("step state during ce", 32'(state_o), 32'd2);
      end
    end
    exp_cnt = exp_cnt + 32'd1;
    check("debounce pulses", 32'(pulses), 32'd1);
    check("debounce ce_count", ce_count, exp_cnt);
    check("debounce end state", 32'(state_o), 32'd0);
    btn_step = 1'b0;
    pulses   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_ce) pulses++;
    end
    check("release pulses", 32'(pulses), 32'd0);

    // Breakpoint at 0x10 from a fresh run.
    bp_en = 1'b1;
    bp_pc = 32'h10;
    load_pc(32'd0);
    sw_run = 1'b1;
    run_until_break(200, done, n, first_pc);
    exp_cnt = exp_cnt + 32'd4;
    check("bp reached", 32'(done), 32'd1);
    check("bp pulses", 32'(n), 32'd4);
    check("bp first pc", first_pc, 32'd0);
    check("bp state_o", 32'(state_o), 32'd3);
    check("bp halted", 32'(halted), 32'd1);
    check("bp pc", pc, 32'h10);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_ce) pulses++;
    end
    check("bp hold pulses", 32'(pulses), 32'd0);
    check("bp hold state", 32'(state_o), 32'd3);

    btn_step = 1'b1;
    wait_ce(30, seen);
    check("bp step seen", 32'(seen), 32'd1);
    check("bp step state", 32'(state_o), 32'd2);
    check("bp step halted", 32'(halted), 32'd0);
    tick();
    check("bp step after state", 32'(state_o), 32'd0);
    check("bp step after ce", 32'(cpu_ce), 32'd0);
    btn_step = 1'b0;
    idle(15);
    exp_cnt = exp_cnt + 32'd1;
    check("bp step ce_count", ce_count, exp_cnt);
    check("bp step pc", pc, 32'h14);

    // Resume from a breakpoint: the first issue at the matching PC goes through.
    sw_run = 1'b0;
    idle(6);
    load_pc(32'd0);
    sw_run = 1'b1;
    run_until_break(200, done, n, first_pc);
    exp_cnt = exp_cnt + 32'd4;
    check("rebreak pulses", 32'(n), 32'd4);
    sw_run = 1'b0;
    idle(6);
    check("toggle halt state", 32'(state_o), 32'd0);
    sw_run = 1'b1;
    run_until_break(300, done, n, first_pc);
    exp_cnt = exp_cnt + 32'd8;
    check("resume reached", 32'(done), 32'd1);
    check("resume first pc", first_pc, 32'h10);
    check("resume pulses", 32'(n), 32'd8);
    check("resume pc", pc, 32'h10);
    check("resume ce_count", ce_count, exp_cnt);

    // Asynchronous reset two cycles after a pulse.
    bp_en  = 1'b0;
    sw_run = 1'b0;
    idle(6);
    sw_run = 1'b1;
    wait_ce(40, seen);
    check("pre-reset ce seen", 32'(seen), 32'd1);
    idle(2);
    rstn = 1'b0;
    #1;
    check("async rst cpu_ce", 32'(cpu_ce), 32'd0);
    check("async rst ce_count", ce_count, 32'd0);
    check("async rst state_o", 32'(state_o), 32'd0);
    check("async rst halted", 32'(halted), 32'd1);
    idle(3);
    rstn   = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cpu_ce) pulses++;
    end
    check("post-reset pulses", 32'(pulses), 32'd0);
    check("post-reset state", 32'(state_o), 32'd0);
    sw_run = 1'b0;
    idle(6);
    sw_run = 1'b1;
    wait_ce(20, seen);
    check("post-reset rise ce", 32'(seen), 32'd1);
    check("post-reset ce_count", ce_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/breakpoint controller for the pipelined CPU on the FPGA board. It replaces the free-running CPU clock divider with a single-cycle clock-enable `cpu_ce`. The CPU, dmem and MIO bus run on `clk` and advance only when `cpu_ce` is high. It supports fast/slow free-run, debounced single-step from a push button, and a PC-match breakpoint. It also exports an issued-cycle counter for a display channel.

## Interface
- `DIV_FAST`, default 4: `clk` cycles per CPU cycle in fast run (≥2).
- `DIV_SLOW`, default 50_000_000: `clk` cycles per CPU cycle in slow run (≥2).
- `DEB_CYCLES`, default 1_000_000: consecutive stable samples needed to accept a button level.
- `clk` in 1: 100 MHz system clock. This is the only clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `sw_speed` in 1: 1 selects slow (`DIV_SLOW`), 0 selects fast (`DIV_FAST`). Wired to SW15.
- `sw_run` in 1: run switch. Asynchronous level.
- `btn_step` in 1: raw step push button. Asynchronous, bouncy.
- `bp_en` in 1: breakpoint enable.
- `bp_pc` in 32: breakpoint address.
- `pc` in 32: current CPU fetch PC.
- `cpu_ce` out 1: CPU advance enable. High for exactly one `clk` cycle per CPU cycle.
- `halted` out 1: high in HALT and BREAK.
- `state_o` out 2: current state encoding.
- `ce_count` out 32: number of `cpu_ce` pulses issued.

## Operation
- **Input conditioning**
  - `sw_run` and `btn_step` each pass through a 2-flop synchronizer.
  - `btn_step` is then debounced: the accepted level changes only after `DEB_CYCLES` consecutive equal synchronized samples.
  - A rising edge of the accepted level produces `step_pulse`, one cycle wide.
  - A rising edge of synchronized `sw_run` produces `run_rise`.
- **States**: HALT=00, RUN=01, STEP=10, BREAK=11.
- **HALT**
  - `run_rise` → RUN.
  - `step_pulse` → STEP. If both occur in the same cycle, STEP wins.
  - `sw_run` held high on its own does not start RUN; a rising edge is required.
- **RUN**
  - Divider counter `cnt` is cleared on entry and increments each cycle.
  - When `cnt ≥ DIV−1`, one `cpu_ce` is issued and `cnt` returns to 0. DIV is selected live by `sw_speed`; the `≥` compare handles a speed change mid-count.
  - Breakpoint check happens at each issue point: if `bp_en` && `pc==bp_pc`, no pulse is issued and the state goes to BREAK.
  - The first issue point after entering RUN skips the breakpoint check (`bp_skip` flag). This allows resuming from a breakpoint.
  - Synchronized `sw_run`=0 → HALT immediately, with no pending pulse.
  - `step_pulse` is ignored in RUN.
- **STEP**
  - Lasts one cycle and issues exactly one `cpu_ce`.
  - Breakpoint is not checked. Always returns to HALT.
- **BREAK**
  - `step_pulse` → STEP.
  - Synchronized `sw_run`=0 → HALT.
  - `run_rise` is impossible while `sw_run` is high.
- **Counter**: `ce_count` increments on every `cpu_ce` and wraps modulo 2^32.

## Timing
- Reset values:
  - state HALT, `state_o`=00, `halted`=1
  - `cpu_ce`=0, `ce_count`=0
  - `cnt`=0
  - synchronizer and debounce flops 0, `bp_skip`=1
- All outputs are registered.
- `cpu_ce` is high in the cycle after the issue decision (RUN) and in the cycle the state is STEP.
- Step latency from a stable `btn_step` rise:
  - 2 synchronizer cycles + `DEB_CYCLES` to `step_pulse`
  - +1 cycle to STEP (`cpu_ce`=1)
  - +1 cycle to HALT
- Run start from an `sw_run` rise: 2 synchronizer cycles + 1 edge-detect cycle to RUN. The first `cpu_ce` follows DIV cycles after RUN entry, and then pulses repeat every DIV cycles.
- `pc` is sampled in the issue-decision cycle. It is stable because the CPU only updates on `cpu_ce`.
- Reset asserted mid-run: `cpu_ce` drops to 0 asynchronously and no partial pulse is produced.
- `halted` and `state_o` update in the same cycle as the state register.

## Structure
- Package `cpu_run_ctrl_pkg`:
  - 2-bit state encodings HALT, RUN, STEP, BREAK
  - default values of `DIV_FAST`, `DIV_SLOW`, `DEB_CYCLES`
- Sub-module `btn_debounce` (parameter `DEB_CYCLES`):
  - 2-flop synchronizer, stability counter and accepted level
  - outputs `level` and `rise_pulse`
  - `sw_run` uses only a synchronizer, not `btn_debounce`
- Top: FSM, divider, breakpoint compare, `ce_count`.

## Test plan
All scenarios use `DIV_FAST`=4, `DIV_SLOW`=16, `DEB_CYCLES`=8.

1. Reset with `sw_run`=1 held → stays HALT, `cpu_ce` never asserts over 100 cycles, `halted`=1, `ce_count`=0.
2. `sw_run` 0→1, `sw_speed`=0 → `cpu_ce` pulses exactly every 4 cycles. Switching `sw_speed`=1 changes the spacing to 16. After 10 fast pulses, `ce_count`=10. `sw_run`=0 → no further pulses, state HALT.
3. `btn_step` bouncing (toggles 1-cycle glitches for 20 cycles), then stable high for 20 cycles → exactly one `cpu_ce`, `ce_count`+1, state returns to 00.
4. Running with `bp_en`=1, `bp_pc`=0x0000_0010, `pc` driven 0x0,0x4,... advancing per `cpu_ce` → pulses at PC 0x0–0xC, then BREAK (`state_o`=11, `halted`=1) with no pulse at 0x10. A subsequent `step_pulse` issues one pulse and the state goes to HALT.
5. From BREAK at `pc`=0x10, toggle `sw_run` 1→0→1 → RUN. The first pulse is issued despite the `pc` match; breakpoint hit again only at the next 0x10 occurrence.
6. `rstn` asserted 2 cycles after a `cpu_ce` in RUN → `cpu_ce`=0, `ce_count`=0 and state HALT asynchronously. After release, no pulses until a new `sw_run` rise.
